audio_sample_pacer: RTL and testbench

Buffers stereo 24-bit samples from the synthesis engines and releases them at a fixed audio rate to the HDMI audio path. It is the stage directly upstream of the HDMI transmitter's `audio_sample_word_in`. It absorbs bursty producer output in a small FIFO and generates its own sample-rate strobe from the 30 MHz clock. Underruns repeat the last sample instead of glitching to zero.

---
 rtl/audio_pkg.sv | 12 +
 rtl/audio_sample_fifo.sv | 54 +++++
 rtl/audio_sample_pacer.sv | 119 +++++++++++
 tb/tb_audio_sample_pacer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types and constants for the sample pacing path.
package audio_pkg;

    localparam int AUDIO_WIDTH   = 24;
    localparam int AUDIO_DIV_48K = 625;

    typedef struct packed {
        logic [AUDIO_WIDTH-1:0] left;
        logic [AUDIO_WIDTH-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock stereo sample FIFO with binary wrapping pointers and occupancy count.
// The head entry is read combinationally so a pop can consume it in the same cycle.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  stereo_sample_t           wr_data_i,
    output stereo_sample_t           rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    stereo_sample_t   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/audio_sample_pacer.sv
// Paces buffered stereo samples out at clock/DIVIDER, repeating the last sample on underrun.
// Optional AUDIO_PACER_STATS_EN adds a saturating 16-bit underrun counter port.
module audio_sample_pacer
    import audio_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DIVIDER = AUDIO_DIV_48K,
    parameter int WIDTH   = AUDIO_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_left,
    input  logic [WIDTH-1:0]        in_right,
    input  logic [2:0]              atten,
    output logic [WIDTH-1:0]        audio_l,
    output logic [WIDTH-1:0]        audio_r,
    output logic                    sample_strobe,
    output logic                    underrun,
    output logic [$clog2(DEPTH):0]  fill_level
`ifdef AUDIO_PACER_STATS_EN
    ,
    output logic [15:0]             underrun_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DIVIDER);

    logic [DW-1:0]  div_cnt_q;
    logic [DW-1:0]  div_cnt_d;
    logic           tick;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           underrun_d;
    logic           strobe_q;
    logic           underrun_q;
    logic [AW:0]    fifo_count;
    stereo_sample_t head;
    stereo_sample_t wr_sample;

    assign tick       = (div_cnt_q == DW'(DIVIDER - 1));
    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (fifo_count != (AW+1)'(DEPTH)) && !reset;
    assign push       = in_valid && in_ready;
    assign pop        = tick && !fifo_empty;
    assign underrun_d = tick && fifo_empty;

    always_comb begin
        div_cnt_d = div_cnt_q + DW'(1);
        if (tick) div_cnt_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q  <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            strobe_q   <= pop;
            underrun_q <= underrun_d;
        end
    end

    assign wr_sample.left  = in_left;
    assign wr_sample.right = in_right;

    audio_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clock),
        .srst_i    (reset),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (wr_sample),
        .rd_data_o (head),
        .count_o   (fifo_count)
    );

    // Channel 0 is left, channel 1 is right; each holds its value between pops.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic signed [WIDTH-1:0] raw;
        logic signed [WIDTH-1:0] sample_q;

        assign raw = (gi == 0) ? head.left : head.right;

        always_ff @(posedge clock) begin
            if (reset) begin
                sample_q <= '0;
            end else if (pop) begin
                sample_q <= raw >>> atten;
            end
        end
    end

    assign audio_l       = g_chan[0].sample_q;
    assign audio_r       = g_chan[1].sample_q;
    assign sample_strobe = strobe_q;
    assign underrun      = underrun_q;
    assign fill_level    = fifo_count;

`ifdef AUDIO_PACER_STATS_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            underrun_cnt_q <= '0;
        end else if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_count = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer with a queue-based reference model checked every cycle.
// Define AUDIO_PACER_STATS_EN to also check underrun_count.
module tb_audio_sample_pacer;

    localparam int DEPTH   = 8;
    localparam int DIVIDER = 625;
    localparam int W       = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_left  = '0;
    logic [W-1:0]  in_right = '0;
    logic [2:0]    atten    = '0;
    logic          in_ready;
    logic [W-1:0]  audio_l;
    logic [W-1:0]  audio_r;
    logic          sample_strobe;
    logic          underrun;
    logic [3:0]    fill_level;
`ifdef AUDIO_PACER_STATS_EN
    logic [15:0]   underrun_count;
`endif

    audio_sample_pacer #(
        .DEPTH   (DEPTH),
        .DIVIDER (DIVIDER),
        .WIDTH   (W)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_left        (in_left),
        .in_right       (in_right),
        .atten          (atten),
        .audio_l        (audio_l),
        .audio_r        (audio_r),
        .sample_strobe  (sample_strobe),
        .underrun       (underrun),
        .fill_level     (fill_level)
`ifdef AUDIO_PACER_STATS_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Floor division by 2**sh on the signed value: what an arithmetic shift must produce.
    function automatic logic [W-1:0] atten_model(input logic [W-1:0] v, input int sh);
        longint s;
        longint p;
        longint q;
        s = longint'(v);
        if (v[W-1]) s = s - 64'sd16777216;
        p = 1;
        for (int k = 0; k < sh; k++) p = p * 2;
        q = s / p;
        if ((s < 0) && (q * p != s)) q = q - 1;
        return q[W-1:0];
    endfunction

    // Reference model: queue of pending samples, ticks every DIVIDER cycles after reset release.
    logic [W-1:0] ql[$];
    logic [W-1:0] qr[$];
    logic [W-1:0] m_l = '0;
    logic [W-1:0] m_r = '0;
    bit           m_strobe = 1'b0;
    bit           m_under  = 1'b0;
    longint       cyc = 0;
    int           m_ucnt = 0;

    always @(posedge clk) begin : model
        bit tick;
        bit can_push;
        if (reset) begin
            ql.delete();
            qr.delete();
            m_l = '0;
            m_r = '0;
            m_strobe = 1'b0;
            m_under  = 1'b0;
            cyc      = 0;
            m_ucnt   = 0;
        end else begin
            tick     = ((cyc + 1) % DIVIDER) == 0;
            can_push = ql.size() < DEPTH;
            m_strobe = 1'b0;
            m_under  = 1'b0;
            if (tick) begin
                if (ql.size() > 0) begin
                    m_l = atten_model(ql.pop_front(), int'(atten));
                    m_r = atten_model(qr.pop_front(), int'(atten));
                    m_strobe = 1'b1;
                end else begin
                    m_under = 1'b1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end
            if (in_valid && can_push) begin
                ql.push_back(in_left);
                qr.push_back(in_right);
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_in_ready", 32'(in_ready), 32'((ql.size() < DEPTH) && !reset));
            chk("cmp_fill_level", 32'(fill_level), 32'(ql.size()));
            chk("cmp_audio_l", 32'(audio_l), 32'(m_l));
            chk("cmp_audio_r", 32'(audio_r), 32'(m_r));
            chk("cmp_sample_strobe", 32'(sample_strobe), 32'(m_strobe));
            chk("cmp_underrun", 32'(underrun), 32'(m_under));
`ifdef AUDIO_PACER_STATS_EN
            chk("cmp_underrun_count", 32'(underrun_count), 32'(m_ucnt));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input bit want_under, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((want_under ? underrun : sample_strobe) !== 1'b1) && (n < max));
        chk(want_under ? "wait_underrun" : "wait_strobe",
            32'(want_under ? underrun : sample_strobe), 32'd1);
    endtask

    function automatic logic [W-1:0] samp_l(input int i);
        return 24'h100000 + 24'(i) * 24'h010101;
    endfunction

    function automatic logic [W-1:0] samp_r(input int i);
        return 24'hE00000 - 24'(i) * 24'd3;
    endfunction

    initial begin : stim
        int n;
        int upos[$];
        int exp_pos[3];
        int acc;
        int idx;
        bit rdy;
        bit strobe_seen;
        exp_pos = '{625, 1250, 1875};

        // Reset, then idle: only underruns, on the exact period grid.
        step();
        chk_en = 1'b1;
        chk("rst_fill_level", 32'(fill_level), 32'd0);
        chk("rst_audio_l", 32'(audio_l), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        strobe_seen = 1'b0;
        for (int s = 1; s <= 2000; s++) begin
            step();
            if (underrun === 1'b1) upos.push_back(s);
            if (sample_strobe !== 1'b0) strobe_seen = 1'b1;
        end
        chk("idle_underrun_n", 32'(upos.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            chk("idle_underrun_pos", 32'((k < upos.size()) ? upos[k] : -1), 32'(exp_pos[k]));
        chk("idle_no_strobe", 32'(strobe_seen), 32'd0);
        $display("idle: underruns=%0d strobe_seen=%0d", upos.size(), strobe_seen);

        // Single sample at unity gain.
        in_left  = 24'h000100;
        in_right = 24'hFFFF00;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_for(1'b0, 1300, n);
        chk("single_audio_l", 32'(audio_l), 32'h000100);
        chk("single_audio_r", 32'(audio_r), 32'hFFFF00);
        step();
        chk("single_strobe_drop", 32'(sample_strobe), 32'd0);
        chk("single_fill_empty", 32'(fill_level), 32'd0);
        $display("single: audio_l=%h audio_r=%h", audio_l, audio_r);

        // Fill to full with in_valid held; one pop reopens exactly one slot.
        acc = 0;
        idx = 0;
        in_left  = samp_l(0);
        in_right = samp_r(0);
        in_valid = 1'b1;
        for (int s = 0; s < 12; s++) begin
            rdy = in_ready;
            step();
            if (rdy) begin
                acc++;
                idx++;
                in_left  = samp_l(idx);
                in_right = samp_r(idx);
            end
        end
        chk("full_accepted", 32'(acc), 32'd8);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_fill_level", 32'(fill_level), 32'd8);
        wait_for(1'b0, 700, n);
        chk("full_pop_reopens", 32'(in_ready), 32'd1);
        chk("full_first_out", 32'(audio_l), 32'(samp_l(0)));
        step();
        in_valid = 1'b0;
        chk("full_ninth_fill", 32'(fill_level), 32'd8);
        chk("full_ninth_ready", 32'(in_ready), 32'd0);
        $display("full: accepted=%0d then ninth fill=%0d", acc, fill_level);
        wait_for(1'b1, 6000, n);

        // Attenuation by 8 keeps sign.
        atten    = 3'd3;
        in_left  = 24'h800000;
        in_right = 24'h7FFFF8;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_for(1'b0, 700, n);
        chk("atten_audio_l", 32'(audio_l), 32'hF00000);
        chk("atten_audio_r", 32'(audio_r), 32'h0FFFFF);
        $display("atten: audio_l=%h audio_r=%h", audio_l, audio_r);

        // One sample then starvation: value held through three underruns.
        reset = 1'b1;
        step();
        reset    = 1'b0;
        atten    = 3'd0;
        in_left  = 24'h123456;
        in_right = 24'hABCDEF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_for(1'b0, 700, n);
        chk("starve_first_l", 32'(audio_l), 32'h123456);
        for (int k = 0; k < 3; k++) begin
            wait_for(1'b1, 700, n);
            chk("starve_hold_l", 32'(audio_l), 32'h123456);
            chk("starve_hold_r", 32'(audio_r), 32'hABCDEF);
        end
`ifdef AUDIO_PACER_STATS_EN
        chk("starve_underrun_count", 32'(underrun_count), 32'd3);
`endif
        $display("starve: held audio_l=%h after 3 underruns", audio_l);

        // Mid-period reset with five samples queued.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_left  = samp_l(20 + i);
            in_right = samp_r(20 + i);
            step();
        end
        in_valid = 1'b0;
        repeat (100) step();
        chk("midrst_fill_before", 32'(fill_level), 32'd5);
        reset = 1'b1;
        step();
        chk("midrst_fill", 32'(fill_level), 32'd0);
        chk("midrst_audio_l", 32'(audio_l), 32'd0);
        chk("midrst_audio_r", 32'(audio_r), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        wait_for(1'b1, 700, n);
        chk("midrst_first_tick", 32'(n), 32'd625);
        $display("midrst: first tick %0d cycles after release", n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
